// File: rtl/otter_branch_pkg.sv
// Shared constants and state encoding for the branch resolution block:
// opcodes, conditional-branch funct3 encodings and the resolver FSM states.
package otter_branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational taken/target resolution for conditional branches, JAL and JALR.
// Targets wrap modulo 2^32; misalign flags a taken target with bit 1 set.
module branch_target_calc
  import otter_branch_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_immB,
  input  logic [31:0] i_immJ,
  input  logic [31:0] i_immI,
  input  logic [31:0] i_rs1,
  input  logic        i_eq,
  input  logic        i_lt,
  input  logic        i_ltu,
  output logic        o_taken,
  output logic [31:0] o_target,
  output logic        o_illegal,
  output logic        o_misalign
);

  // Decode the control-flow opcode into a taken decision and its target
  always_comb begin
    o_taken    = 1'b0;
    o_target   = 32'd0;
    o_illegal  = 1'b0;
    o_misalign = 1'b0;
    case (i_opcode)
      OP_BRANCH: begin
        o_target = i_pc + i_immB;
        case (i_funct3)
          F3_BEQ:  o_taken = i_eq;
          F3_BNE:  o_taken = ~i_eq;
          F3_BLT:  o_taken = i_lt;
          F3_BGE:  o_taken = ~i_lt;
          F3_BLTU: o_taken = i_ltu;
          F3_BGEU: o_taken = ~i_ltu;
          default: o_illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        o_taken  = 1'b1;
        o_target = i_pc + i_immJ;
      end
      OP_JALR: begin
        o_taken  = 1'b1;
        o_target = (i_rs1 + i_immI) & 32'hFFFF_FFFE;
      end
      default: begin
        o_taken = 1'b0;
      end
    endcase
    o_misalign = o_taken & o_target[1];
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution FSM: accepts one execute-stage instruction, issues a
// redirect handshake and holds flush. Optional counters under BRANCH_STATS_EN.
module branch_resolve
  import otter_branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
)
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        exValid,
  output logic        exReady,
  input  logic [31:0] exPc,
  input  logic [6:0]  exOpcode,
  input  logic [2:0]  exFunct3,
  input  logic [31:0] exImmB,
  input  logic [31:0] exImmJ,
  input  logic [31:0] exImmI,
  input  logic [31:0] exRs1,
  input  logic        branchEqual,
  input  logic        branchLessThan,
  input  logic        branchLessThanUnsigned,
  output logic        redirectValid,
  output logic [31:0] redirectPc,
  input  logic        redirectReady,
  output logic        flush,
  output logic        illegalBranch,
  output logic        misalignTrap
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] branchCount,
  output logic [31:0] takenCount
`endif
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_redirectPc;
  logic [31:0] w_redirectPcNext;
  logic [2:0]  r_flushCnt;
  logic [2:0]  w_flushCntNext;
  logic        r_exReady;
  logic        r_redirectValid;
  logic        r_flush;
  logic        r_illegal;
  logic        r_misalign;

  logic        w_accept;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_illegal;
  logic        w_misalign;

  assign w_accept = exValid & (r_state == IDLE);

  branch_target_calc u_calc (
    .i_opcode   (exOpcode),
    .i_funct3   (exFunct3),
    .i_pc       (exPc),
    .i_immB     (exImmB),
    .i_immJ     (exImmJ),
    .i_immI     (exImmI),
    .i_rs1      (exRs1),
    .i_eq       (branchEqual),
    .i_lt       (branchLessThan),
    .i_ltu      (branchLessThanUnsigned),
    .o_taken    (w_taken),
    .o_target   (w_target),
    .o_illegal  (w_illegal),
    .o_misalign (w_misalign)
  );

  // Next-state, redirect target and flush countdown
  always_comb begin
    w_stateNext      = r_state;
    w_redirectPcNext = r_redirectPc;
    w_flushCntNext   = r_flushCnt;
    case (r_state)
      IDLE: begin
        if (w_accept && w_taken && !w_misalign) begin
          w_stateNext      = REDIRECT;
          w_redirectPcNext = w_target;
        end else begin
          w_stateNext = IDLE;
        end
      end
      REDIRECT: begin
        if (redirectReady) begin
          if (FLUSH_CYCLES == 0) begin
            w_stateNext = IDLE;
          end else begin
            w_stateNext    = FLUSH;
            w_flushCntNext = FLUSH_INIT;
          end
        end else begin
          w_stateNext = REDIRECT;
        end
      end
      FLUSH: begin
        if (r_flushCnt == 3'd0) begin
          w_stateNext = IDLE;
        end else begin
          w_flushCntNext = r_flushCnt - 3'd1;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and registered outputs; status flags decode the upcoming state
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state         <= IDLE;
      r_redirectPc    <= 32'd0;
      r_flushCnt      <= 3'd0;
      r_exReady       <= 1'b1;
      r_redirectValid <= 1'b0;
      r_flush         <= 1'b0;
      r_illegal       <= 1'b0;
      r_misalign      <= 1'b0;
    end else begin
      r_state         <= w_stateNext;
      r_redirectPc    <= w_redirectPcNext;
      r_flushCnt      <= w_flushCntNext;
      r_exReady       <= (w_stateNext == IDLE);
      r_redirectValid <= (w_stateNext == REDIRECT);
      r_flush         <= (w_stateNext == FLUSH);
      r_illegal       <= w_accept & w_illegal;
      r_misalign      <= w_accept & w_misalign;
    end
  end

  assign exReady       = r_exReady;
  assign redirectValid = r_redirectValid;
  assign redirectPc    = r_redirectPc;
  assign flush         = r_flush;
  assign illegalBranch = r_illegal;
  assign misalignTrap  = r_misalign;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_branchCount;
  logic [31:0] r_takenCount;
  logic        w_isBranch;

  assign w_isBranch = (exOpcode == OP_BRANCH);

  // Saturating counters of accepted and redirecting conditional branches
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_branchCount <= 32'd0;
      r_takenCount  <= 32'd0;
    end else if (w_accept && w_isBranch) begin
      if (r_branchCount != 32'hFFFF_FFFF) begin
        r_branchCount <= r_branchCount + 32'd1;
      end
      if (w_taken && !w_misalign && (r_takenCount != 32'hFFFF_FFFF)) begin
        r_takenCount <= r_takenCount + 32'd1;
      end
    end
  end

  assign branchCount = r_branchCount;
  assign takenCount  = r_takenCount;
`endif

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush stays high after a redirect is accepted (legal 0..7).
REQ-002 SHALL have ports: CLK  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have ports: RST_N  in  1  reset; synchronous, active-low.
REQ-004 SHALL have ports: exValid  in  1  execute stage presents an instruction.
REQ-005 SHALL have ports: exReady  out  1  block can accept an instruction.
REQ-006 SHALL have ports: exPc  in  32  PC of the instruction.
REQ-007 SHALL have ports: exOpcode  in  7  and exFunct3  in  3  decoded fields.
REQ-008 SHALL have ports: exImmB, exImmJ, exImmI  in  32 each  sign-extended B/J/I immediates.
REQ-009 SHALL have ports: exRs1  in  32  rs1 value, used by JALR.
REQ-010 SHALL have ports: branchEqual, branchLessThan, branchLessThanUnsigned  in  1 each  comparison flags from the branch condition generator.
REQ-011 SHALL have ports: redirectValid  out  1, redirectPc  out  32, redirectReady  in  1  handshake to PC select.
REQ-012 SHALL have ports: flush  out  1  kill IF/ID contents.
REQ-013 SHALL have ports: illegalBranch  out  1, misalignTrap  out  1  one-cycle error pulses.

Function
REQ-014 SHALL implement states IDLE, REDIRECT, FLUSH; exReady=1 only in IDLE.
REQ-015 SHALL accept an instruction on a rising edge where exValid && exReady; exValid in other states is ignored.
REQ-016 SHALL, for opcode 1100011, resolve taken per funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu; target = exPc+exImmB.
REQ-017 SHALL treat funct3 010/011 with branch opcode as not-taken and pulse illegalBranch for the cycle after accept.
REQ-018 SHALL treat opcode 1101111 (JAL) as taken, target exPc+exImmJ; opcode 1100111 (JALR) as taken, target (exRs1+exImmI) with bit0 cleared.
REQ-019 SHALL compute all target sums modulo 2^32 (wrap, no overflow flag).
REQ-020 SHALL, on a taken target with bit1 set, stay IDLE, pulse misalignTrap one cycle after accept, and not redirect.
REQ-021 SHALL stay IDLE with no output activity for not-taken or non-control opcodes.
REQ-022 SHALL, on a legal taken accept at edge N, enter REDIRECT with redirectValid=1 and registered redirectPc from cycle N+1.
REQ-023 SHALL hold redirectValid and redirectPc stable until redirectReady=1 is sampled.
REQ-024 SHALL, on redirect handshake, enter FLUSH with flush=1 for exactly FLUSH_CYCLES cycles, then IDLE; FLUSH_CYCLES=0 goes straight to IDLE.
REQ-025 SHALL keep redirectValid=0 in FLUSH and IDLE, and flush=0 outside FLUSH.

Reset
REQ-026 SHALL, when RST_N=0 on a rising edge, enter IDLE and clear redirectValid, redirectPc, flush, illegalBranch, misalignTrap, flush counter and stats counters to 0, abandoning any redirect or flush in progress.
REQ-027 SHALL drive exReady=1 on the first cycle after reset release.

Configuration
REQ-028 SHALL, with BRANCH_STATS_EN defined, add outputs branchCount[31:0] (accepted conditional branches) and takenCount[31:0] (taken conditional branches, after the misaligned-target check of REQ-020), both saturating at 0xFFFFFFFF.
REQ-029 SHALL, without BRANCH_STATS_EN, omit these ports and counters entirely.

Structure
REQ-030 SHALL place opcode constants, funct3 branch encodings and the state enum in shared package otter_branch_pkg.
REQ-031 SHALL implement target/taken computation in combinational sub-module branch_target_calc.

Verification
REQ-032 SHALL cover: BEQ, branchEqual=1, exPc=0x100, exImmB=0x20 -> redirectValid next cycle, redirectPc=0x120, flush 2 cycles after redirectReady.
REQ-033 SHALL cover: BLTU with branchLessThanUnsigned=0 -> no redirect, exReady stays 1; funct3=010 -> illegalBranch one-cycle pulse.
REQ-034 SHALL cover: JALR exRs1=0x1001, exImmI=0x3 -> redirectPc=0x1004; JAL exPc=0xFFFFFFF0, exImmJ=0x20 -> redirectPc=0x10.
REQ-035 SHALL cover: redirectReady held 0 for 5 cycles -> redirectPc stable, exValid ignored; RST_N=0 mid-FLUSH -> IDLE, flush=0 next cycle.
REQ-036 SHALL cover: JAL target 0x102 -> misalignTrap pulse, no redirect; with BRANCH_STATS_EN, 3 branches (2 taken) -> branchCount=3, takenCount=2.
